// File: rtl/rob_register_file_if.sv
// Dispatch/commit-side bundle for the ROB-tagged register file.
// The master drives read addresses, renames, commits and flush; the slave (register file) returns read results.
interface rob_register_file_if #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int ROB_DEPTH = 8,
  parameter int NRD       = 2
);
  localparam int AW = $clog2(NREG);
  localparam int TW = $clog2(ROB_DEPTH);

  logic [NRD*AW-1:0]   rs_in;
  logic [NRD*XLEN-1:0] rd_data_out;
  logic [NRD*TW-1:0]   rd_tag_out;
  logic [NRD-1:0]      rd_busy_out;
  logic                ren_valid_in;
  logic [AW-1:0]       ren_rd_in;
  logic [TW-1:0]       ren_tag_in;
  logic                cm_valid_in;
  logic [AW-1:0]       cm_rd_in;
  logic [TW-1:0]       cm_tag_in;
  logic [XLEN-1:0]     cm_data_in;
  logic                flush_in;
  logic [AW:0]         busy_cnt_out;

  modport master (
    output rs_in, ren_valid_in, ren_rd_in, ren_tag_in,
    output cm_valid_in, cm_rd_in, cm_tag_in, cm_data_in, flush_in,
    input  rd_data_out, rd_tag_out, rd_busy_out, busy_cnt_out
  );

  modport slave (
    input  rs_in, ren_valid_in, ren_rd_in, ren_tag_in,
    input  cm_valid_in, cm_rd_in, cm_tag_in, cm_data_in, flush_in,
    output rd_data_out, rd_tag_out, rd_busy_out, busy_cnt_out
  );
endinterface

// File: rtl/rob_register_file.sv
// Architectural register file with per-register ROB rename tags; combinational reads with commit bypass.
// Zero read latency, one-edge update latency; no backpressure, a rename or commit is accepted every cycle.
module rob_register_file #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int ROB_DEPTH = 8,
  parameter int NRD       = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  rob_register_file_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] regs [NREG];
  logic [TW-1:0]   tag  [NREG];
  logic [NREG-1:0] busy;
  logic [CW-1:0]   busy_cnt;

  logic ren_ok;
  logic cm_ok;
  logic cm_clr;
  logic cnt_inc;
  logic cnt_dec;

  assign ren_ok = bus.ren_valid_in && (bus.ren_rd_in != '0) && !bus.flush_in;
  assign cm_ok  = bus.cm_valid_in && (bus.cm_rd_in != '0);
  // A commit only releases a register it still owns and that is not being re-renamed this edge.
  assign cm_clr = cm_ok && busy[bus.cm_rd_in] && (tag[bus.cm_rd_in] == bus.cm_tag_in)
                  && !(ren_ok && (bus.ren_rd_in == bus.cm_rd_in));
  assign cnt_inc = ren_ok && !busy[bus.ren_rd_in];
  assign cnt_dec = cm_clr && !bus.flush_in;

  assign bus.busy_cnt_out = busy_cnt;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] rs;
    logic          nz;
    logic          hit;

    assign rs  = bus.rs_in[p*AW +: AW];
    assign nz  = (rs != '0);
    assign hit = nz && bus.cm_valid_in && (bus.cm_rd_in == rs);

    assign bus.rd_data_out[p*XLEN +: XLEN] = !nz ? '0 : (hit ? bus.cm_data_in : regs[rs]);
    assign bus.rd_tag_out[p*TW +: TW]      = nz ? tag[rs] : '0;
    assign bus.rd_busy_out[p]              = nz && busy[rs] && !(hit && (tag[rs] == bus.cm_tag_in));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (cm_ok) begin
        regs[bus.cm_rd_in] <= bus.cm_data_in;
      end
      if (bus.flush_in) begin
        busy     <= '0;
        busy_cnt <= '0;
      end else begin
        if (cm_clr) begin
          busy[bus.cm_rd_in] <= 1'b0;
        end
        if (ren_ok) begin
          busy[bus.ren_rd_in] <= 1'b1;
          tag[bus.ren_rd_in]  <= bus.ren_tag_in;
        end
        busy_cnt <= busy_cnt + CW'(cnt_inc) - CW'(cnt_dec);
      end
    end
  end
endmodule
